vproc_opfetch_seq: RTL and testbench
====================================

Name: vproc_opfetch_seq

Overview:
- Sequential operand-fetch sequencer for vector instructions.
- Accepts one instruction descriptor: register group size (EMUL), plus per-operand register flag, base register and narrow flag for up to OP_CNT source operands.
- Walks the register group, emitting one registered fetch-control beat per cycle: register address, fetch, shift, clear-hazard.
- Sits between the decode/dispatch queue and each functional unit's operand read stage.
- Replaces the per-instruction combinational fetch-info update with a parametrised, back-pressured sequencer.

Parameters:
- OP_CNT, 3, number of source operand channels (1..4).
- PARTS, 4, cycles needed to stream one vector register through the unit datapath (power of two, 1..16).
- ID_W, 5, width of the instruction tag passed through.

Ports:
- clk_i  in  1  clock.
- async_rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  descriptor valid.
- in_ready_o  out  1  descriptor accepted when in_valid_i & in_ready_o.
- in_id_i  in  ID_W  instruction tag.
- in_emul_i  in  2  register group size: 00=1, 01=2, 10=4, 11=8 registers.
- in_vreg_i  in  OP_CNT  operand n is a vector register (else scalar: no fetch activity).
- in_base_addr_i  in  5*OP_CNT  base register of operand n; slice [5n+4:5n].
- in_narrow_i  in  OP_CNT  operand n is read at half rate (narrowing source).
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  beat consumed when out_valid_o & out_ready_i.
- out_id_o  out  ID_W  tag of the current instruction.
- out_vreg_addr_o  out  5*OP_CNT  register address per operand.
- out_fetch_o  out  OP_CNT  read register file for operand n this beat.
- out_shift_o  out  OP_CNT  shift operand n's buffer this beat.
- out_clear_hazard_o  out  OP_CNT  last beat using operand n's current register.
- out_first_o  out  1  first beat of the instruction.
- out_last_o  out  1  final beat of the instruction.
- busy_o  out  1  an instruction is in progress.

Behaviour:
- Reset (async assert, sync release): busy_o=0, out_valid_o=0, counter=0; all out_* vectors and flags 0; out_id_o=0.
- States:
  - IDLE: in_ready_o=1.
  - RUN: in_ready_o = out_valid_o & out_ready_i & out_last_o, giving zero-bubble back-to-back acceptance.
- Acceptance in cycle t:
  - Capture the descriptor.
  - Beat 0 is valid at t+1 (one-cycle registered latency).
- Beat counter cnt = {mul[2:0], part[log2(PARTS)-1:0]}; the part field is absent when PARTS=1.
- Beats per instruction = (1<<emul)*PARTS; cnt advances only on an accepted beat.
- Output stays stable while out_valid_o & !out_ready_i.
- Per operand n, gated by vreg[n] (all fetch/shift/clear outputs 0 when vreg[n]=0):
  - Non-narrow:
    - addr = base | {2'b00, mul}.
    - fetch = (part==0).
    - clear_hazard = (part==PARTS-1).
  - Narrow:
    - addr = base | {2'b00, mul>>1}.
    - fetch = (part==0 & mul[0]==0).
    - clear_hazard = (part==PARTS-1 & (mul[0]==1 | last beat)).
  - shift = vreg & !fetch.
- out_first_o = (cnt==0); out_last_o = (cnt == beats-1).
- Base alignment: base is ORed, not added. A misaligned base is a caller error and the behaviour is undefined.
- Scalar operands: addr output is don't-care but driven with the base value.
- Last beat accepted:
  - If a new descriptor is valid, it loads in the same cycle and its beat 0 follows next cycle.
  - Otherwise return to IDLE: busy_o=0, out_valid_o=0.
- Reset mid-instruction aborts immediately with no further beats.

Test Plan:
- emul=00, PARTS=4, op0 vreg base=8 non-narrow, out_ready=1 → 4 beats, addr 8 each.
  - fetch=1,0,0,0; shift=0,1,1,1; clear=0,0,0,1.
  - first on beat 0, last on beat 3, busy drops the cycle after.
- emul=10, op1 base=16 narrow → addr 16 on beats 0-7 and 17 on beats 8-15.
  - fetch only on beats 0 and 8; clear only on beats 7 and 15.
- Two descriptors back-to-back (ids 3, 4), out_ready held 1 → ids contiguous with no idle cycle; in_ready high only on id 3's last beat.
- Stall out_ready=0 for 3 cycles at beat 2 → outputs frozen; counter resumes at beat 2, total beat count unchanged.
- op2 scalar (vreg=0), emul=11 → 32 beats; op2 fetch/shift/clear all 0 throughout.
- Assert async_rst_ni low at beat 5 of an emul=01 instruction → outputs 0 immediately; next descriptor starts from beat 0.

Source files
------------

// File: rtl/vproc_opfetch_seq.sv
// Operand-fetch sequencer: walks a vector register group and emits one fetch-control
// beat per cycle per instruction, with back-pressure and zero-bubble descriptor hand-over.
module vproc_opfetch_seq #(
    parameter int unsigned OP_CNT = 3,
    parameter int unsigned PARTS  = 4,
    parameter int unsigned ID_W   = 5
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ID_W-1:0]       in_id_i,
    input  logic [1:0]            in_emul_i,
    input  logic [OP_CNT-1:0]     in_vreg_i,
    input  logic [5*OP_CNT-1:0]   in_base_addr_i,
    input  logic [OP_CNT-1:0]     in_narrow_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ID_W-1:0]       out_id_o,
    output logic [5*OP_CNT-1:0]   out_vreg_addr_o,
    output logic [OP_CNT-1:0]     out_fetch_o,
    output logic [OP_CNT-1:0]     out_shift_o,
    output logic [OP_CNT-1:0]     out_clear_hazard_o,
    output logic                  out_first_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    // With PARTS=1 the part field is kept one bit wide but pinned to zero.
    localparam int unsigned   PW       = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam logic [PW-1:0] PART_MAX = PW'(PARTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_id;
    logic [1:0]          r_emul;
    logic [OP_CNT-1:0]   r_vreg;
    logic [OP_CNT-1:0]   r_narrow;
    logic [5*OP_CNT-1:0] r_base;
    logic [2:0]          r_mul;
    logic [PW-1:0]       r_part;

    logic       w_valid;
    logic       w_beat_acc;
    logic       w_last;
    logic       w_load;
    logic       w_part_zero;
    logic       w_part_last;
    logic [2:0] w_mul_max;

    assign w_valid     = (r_state == RUN);
    assign w_part_zero = (r_part == '0);
    assign w_part_last = (r_part == PART_MAX);
    assign w_mul_max   = {r_emul[1] & r_emul[0], r_emul[1], r_emul[1] | r_emul[0]};
    assign w_last      = w_valid & w_part_last & (r_mul == w_mul_max);
    assign w_beat_acc  = w_valid & out_ready_i;
    assign in_ready_o  = (r_state == IDLE) | (w_beat_acc & w_last);
    assign w_load      = in_valid_i & in_ready_o;
    assign out_valid_o = w_valid;
    assign busy_o      = w_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid_i) w_state_nxt = RUN;
            RUN:     if (w_beat_acc && w_last && !in_valid_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_state  <= IDLE;
            r_id     <= '0;
            r_emul   <= '0;
            r_vreg   <= '0;
            r_narrow <= '0;
            r_base   <= '0;
            r_mul    <= '0;
            r_part   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_id     <= in_id_i;
                r_emul   <= in_emul_i;
                r_vreg   <= in_vreg_i;
                r_narrow <= in_narrow_i;
                r_base   <= in_base_addr_i;
                r_mul    <= '0;
                r_part   <= '0;
            end else if (w_beat_acc) begin
                if (w_part_last) begin
                    r_part <= '0;
                    r_mul  <= r_mul + 3'd1;
                end else begin
                    r_part <= r_part + PW'(1);
                end
            end
        end
    end

    // Narrow sources consume one register per two destination registers, hence mul>>1.
    always_comb begin
        out_id_o           = '0;
        out_vreg_addr_o    = '0;
        out_fetch_o        = '0;
        out_shift_o        = '0;
        out_clear_hazard_o = '0;
        out_first_o        = 1'b0;
        out_last_o         = 1'b0;
        if (w_valid) begin
            out_id_o    = r_id;
            out_first_o = (r_mul == 3'd0) & w_part_zero;
            out_last_o  = w_last;
            for (int n = 0; n < OP_CNT; n++) begin
                if (r_vreg[n]) begin
                    out_vreg_addr_o[5*n +: 5] = r_base[5*n +: 5]
                        | {2'b00, (r_narrow[n] ? {1'b0, r_mul[2:1]} : r_mul)};
                    out_fetch_o[n] = w_part_zero & (~r_narrow[n] | ~r_mul[0]);
                    out_clear_hazard_o[n] = w_part_last & (~r_narrow[n] | r_mul[0] | w_last);
                    out_shift_o[n] = ~out_fetch_o[n];
                end else begin
                    out_vreg_addr_o[5*n +: 5] = r_base[5*n +: 5];
                end
            end
        end
    end

endmodule

// File: tb/tb_vproc_opfetch_seq.sv
// Scoreboard bench for vproc_opfetch_seq: the driver queues expected beats on acceptance,
// a negedge monitor pops and compares every consumed beat.
module tb_vproc_opfetch_seq;

    localparam int OP_CNT = 3;
    localparam int PARTS  = 4;
    localparam int ID_W   = 5;

    logic                clk_i = 1'b0;
    logic                async_rst_ni;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [ID_W-1:0]     in_id_i;
    logic [1:0]          in_emul_i;
    logic [OP_CNT-1:0]   in_vreg_i;
    logic [5*OP_CNT-1:0] in_base_addr_i;
    logic [OP_CNT-1:0]   in_narrow_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [ID_W-1:0]     out_id_o;
    logic [5*OP_CNT-1:0] out_vreg_addr_o;
    logic [OP_CNT-1:0]   out_fetch_o;
    logic [OP_CNT-1:0]   out_shift_o;
    logic [OP_CNT-1:0]   out_clear_hazard_o;
    logic                out_first_o;
    logic                out_last_o;
    logic                busy_o;

    vproc_opfetch_seq #(.OP_CNT(OP_CNT), .PARTS(PARTS), .ID_W(ID_W)) dut (
        .clk_i(clk_i), .async_rst_ni(async_rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_id_i(in_id_i),
        .in_emul_i(in_emul_i), .in_vreg_i(in_vreg_i), .in_base_addr_i(in_base_addr_i),
        .in_narrow_i(in_narrow_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_id_o(out_id_o), .out_vreg_addr_o(out_vreg_addr_o), .out_fetch_o(out_fetch_o),
        .out_shift_o(out_shift_o), .out_clear_hazard_o(out_clear_hazard_o),
        .out_first_o(out_first_o), .out_last_o(out_last_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  id;
        logic [14:0] addr;
        logic [2:0]  fetch;
        logic [2:0]  shift;
        logic [2:0]  clear;
        logic        first;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t mon_a, mon_e;
    int    wait_cnt;
    logic  acc_last;
    logic [4:0] acc_id;

    always @(posedge clk_i) cyc = cyc + 1;

    function automatic beat_t cur();
        beat_t r;
        r.id = out_id_o; r.addr = out_vreg_addr_o; r.fetch = out_fetch_o;
        r.shift = out_shift_o; r.clear = out_clear_hazard_o;
        r.first = out_first_o; r.last = out_last_o;
        return r;
    endfunction

    function automatic beat_t model(input logic [4:0] id, input logic [1:0] emul,
                                    input logic [2:0] vreg, input logic [14:0] base,
                                    input logic [2:0] narrow, input int b);
        beat_t r;
        int beats, part;
        logic [2:0] m;
        logic [4:0] bs;
        beats = (1 << emul) * PARTS;
        part  = b % PARTS;
        m     = 3'(b / PARTS);
        r = '0;
        r.id = id;
        r.first = (b == 0);
        r.last = (b == beats - 1);
        for (int n = 0; n < OP_CNT; n++) begin
            bs = base[5*n +: 5];
            if (!vreg[n]) begin
                r.addr[5*n +: 5] = bs;
            end else begin
                r.addr[5*n +: 5] = bs | {2'b00, (narrow[n] ? (m >> 1) : m)};
                r.fetch[n] = (part == 0) && (!narrow[n] || !m[0]);
                r.clear[n] = (part == PARTS - 1) && (!narrow[n] || m[0] || (b == beats - 1));
                r.shift[n] = !r.fetch[n];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (async_rst_ni && out_valid_o && out_ready_i) begin
            mon_a = cur();
            obs_q.push_back(mon_a);
            obs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL beat: got %h expected %h", mon_a, mon_e);
                end
            end
        end
    end

    task automatic send(input logic [4:0] id, input logic [1:0] emul, input logic [2:0] vreg,
                        input logic [14:0] base, input logic [2:0] narrow);
        bit ok;
        ok = 0;
        wait_cnt = 0;
        in_valid_i = 1'b1; in_id_i = id; in_emul_i = emul;
        in_vreg_i = vreg; in_base_addr_i = base; in_narrow_i = narrow;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (in_ready_o) begin ok = 1; break; end
            wait_cnt++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready for id %0d", id);
        end else begin
            acc_last = out_last_o;
            acc_id = out_id_o;
            for (int b = 0; b < (1 << emul) * PARTS; b++)
                exp_q.push_back(model(id, emul, vreg, base, narrow, b));
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i); #1;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic poll_obs(input int n);
        for (int k = 0; k < 100; k++) begin
            if (obs_q.size() >= n) break;
            @(posedge clk_i); #1;
        end
        check("poll_obs_count", obs_q.size(), n);
    endtask

    beat_t snap;
    int bad;

    initial begin
        async_rst_ni = 1'b0; in_valid_i = 1'b0; in_id_i = '0; in_emul_i = '0;
        in_vreg_i = '0; in_base_addr_i = '0; in_narrow_i = '0; out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_beat", cur(), 0);
        check("rst_in_ready", in_ready_o, 1);
        async_rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // single register, op0 base 8
        obs_q.delete(); obs_cyc.delete();
        send(5'd1, 2'b00, 3'b001, {5'd0, 5'd0, 5'd8}, 3'b000);
        drain();
        check("t1_busy_after", busy_o, 0);
        check("t1_valid_after", out_valid_o, 0);
        check("t1_beats", obs_q.size(), 4);
        for (int b = 0; b < obs_q.size() && b < 4; b++) begin
            check("t1_addr", obs_q[b].addr[4:0], 8);
            check("t1_fetch", obs_q[b].fetch[0], (b == 0));
            check("t1_shift", obs_q[b].shift[0], (b != 0));
            check("t1_clear", obs_q[b].clear[0], (b == 3));
            check("t1_first", obs_q[b].first, (b == 0));
            check("t1_last", obs_q[b].last, (b == 3));
        end

        // emul=4, op1 narrow base 16
        obs_q.delete(); obs_cyc.delete();
        send(5'd2, 2'b10, 3'b010, {5'd0, 5'd16, 5'd0}, 3'b010);
        drain();
        check("t2_beats", obs_q.size(), 16);
        for (int b = 0; b < obs_q.size() && b < 16; b++) begin
            check("t2_addr", obs_q[b].addr[9:5], (b < 8) ? 16 : 17);
            check("t2_fetch", obs_q[b].fetch[1], (b == 0 || b == 8));
            check("t2_clear", obs_q[b].clear[1], (b == 7 || b == 15));
        end

        // back-to-back ids 3 and 4
        obs_q.delete(); obs_cyc.delete();
        send(5'd3, 2'b00, 3'b001, {5'd0, 5'd0, 5'd8}, 3'b000);
        send(5'd4, 2'b00, 3'b001, {5'd0, 5'd0, 5'd8}, 3'b000);
        check("t3_ready_wait", wait_cnt, 3);
        check("t3_ready_on_last", acc_last, 1);
        check("t3_ready_id", acc_id, 3);
        drain();
        check("t3_beats", obs_q.size(), 8);
        for (int i = 1; i < obs_q.size(); i++)
            check("t3_contiguous", obs_cyc[i] - obs_cyc[0], i);

        // stall at beat 2
        obs_q.delete(); obs_cyc.delete();
        send(5'd5, 2'b00, 3'b101, {5'd8, 5'd0, 5'd8}, 3'b000);
        poll_obs(2);
        out_ready_i = 1'b0;
        snap = cur();
        check("t4_stall_beat2_first", snap.first, 0);
        repeat (3) begin
            @(negedge clk_i);
            check("t4_stall_hold", cur(), snap);
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        drain();
        check("t4_beats", obs_q.size(), 4);
        if (obs_q.size() > 2) check("t4_resume_beat2", obs_q[2], snap);

        // op2 scalar, emul=8
        obs_q.delete(); obs_cyc.delete();
        send(5'd6, 2'b11, 3'b011, {5'd24, 5'd8, 5'd0}, 3'b000);
        drain();
        check("t5_beats", obs_q.size(), 32);
        bad = 0;
        for (int b = 0; b < obs_q.size(); b++)
            if (obs_q[b].fetch[2] || obs_q[b].shift[2] || obs_q[b].clear[2]
                || obs_q[b].addr[14:10] != 5'd24) bad++;
        check("t5_scalar_quiet", bad, 0);

        // reset mid-instruction at beat 5
        obs_q.delete(); obs_cyc.delete();
        send(5'd7, 2'b01, 3'b001, {5'd0, 5'd0, 5'd8}, 3'b000);
        poll_obs(5);
        async_rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", out_valid_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_beat", cur(), 0);
        @(posedge clk_i); #1;
        async_rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("t6_no_beats_after_rst", obs_q.size(), 5);
        obs_q.delete(); obs_cyc.delete();
        send(5'd8, 2'b01, 3'b001, {5'd0, 5'd0, 5'd16}, 3'b000);
        check("t6_restart_first", out_first_o, 1);
        check("t6_restart_addr", out_vreg_addr_o[4:0], 16);
        drain();
        check("t6_beats", obs_q.size(), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
